bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit synchronous BCD down counter, the counting-down counterpart to the team's single-digit BCD up counter.
- Used for countdown timers and downstream decrement sequencing: load a decimal preset, decrement on enable, flag zero and underflow.
- Packed BCD output, one 4-bit nibble per decimal digit. Digit 0 is the least significant digit, in OUT[3:0].

Parameters:
- DIGITS, 2, number of BCD digits (1..8); OUT width = 4*DIGITS.
- WRAP, 1, underflow policy. 1: all-zero decrements to all-nines. 0: counter holds at all-zero.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- en  input  1  decrement enable; one decrement per clock while high.
- load  input  1  synchronous preset strobe.
- load_val  input  4*DIGITS  packed BCD preset value.
- OUT  output  4*DIGITS  registered packed BCD count.
- zero  output  1  combinational; 1 when OUT is all zeros.
- borrow  output  1  registered underflow pulse.
- load_err  output  1  registered; 1 for one cycle after a load containing a non-BCD nibble.

Behaviour:
- Reset:
  - Synchronous, active-high. On a posedge with rst=1: OUT=0, borrow=0, load_err=0. zero therefore reads 1.
  - rst overrides load and en in the same cycle.
  - Asserting rst mid-count discards the count at the next edge. There is no asynchronous path.
- Priority per edge: rst > load > en. en is ignored in a load cycle; there is no decrement on the loaded value that cycle.
- Load:
  - Each nibble of load_val that is 0..9 is loaded as is.
  - Any nibble A..F is clamped to 9, and load_err=1 on the following cycle only.
  - On a load edge, borrow is 0.
- Decrement (en=1, no rst, no load):
  - Digit 0 decrements by 1.
  - Any digit at 0 that receives a borrow-in becomes 9 and propagates the borrow to the next higher digit.
  - A digit that receives no borrow-in holds its value.
  - The full ripple across all DIGITS resolves within one cycle.
  - Latency: OUT reflects the decrement at the edge that samples en=1.
- Underflow (OUT all zero, en=1):
  - WRAP=1: OUT becomes all nines, and borrow=1 for exactly that one cycle, coincident with the wrapped value.
  - WRAP=0: OUT holds at zero and borrow stays 0.
- borrow and load_err are 0 in every cycle not described above. They are pulses, not sticky flags.
- en=0: OUT holds and borrow=0.
- OUT never holds a non-BCD nibble in any reachable state. An implementation must not rely on default-case recovery for this; it is guaranteed by construction.

Test Plan:
- Reset, then en=0 for 3 cycles (DIGITS=2) -> OUT=0x00, zero=1, borrow=0, load_err=0 throughout.
- Load 0x21, then en=1 for 3 cycles -> OUT sequence 0x20, 0x19, 0x18. The digit-1 borrow at 0x20->0x19 produces borrow=0.
- WRAP=1: load 0x01, en=1 for 2 cycles -> OUT 0x00 (zero=1), then 0x99 with borrow=1 for that cycle only; next en cycle gives 0x98 and borrow=0.
- WRAP=0: load 0x00, en=1 for 4 cycles -> OUT stays 0x00, zero=1, borrow never asserts.
- Load 0x3C with en=1 in the same cycle -> OUT=0x39, load_err=1 for one cycle. No decrement that cycle; next en cycle gives 0x38.
- Load 0x57, en=1 for 2 cycles, then rst=1 and load=1 together -> OUT=0x00 at the reset edge, zero=1; the load is ignored.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Multi-digit synchronous BCD down counter with load clamping, a zero flag and an underflow pulse.
// Digit 0 sits in OUT[3:0]; the borrow ripple across all digits settles within one cycle.

module bcd_digit (
  input  logic [3:0] d,
  input  logic       borrow_in,
  input  logic [3:0] load_nib,
  output logic [3:0] dec,
  output logic       borrow_out,
  output logic [3:0] load_clamped,
  output logic       load_bad
);
  always_comb begin
    dec        = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == 4'd0) begin
        dec        = 4'd9;
        borrow_out = 1'b1;
      end else begin
        dec        = d - 4'd1;
      end
    end
  end

  // Non-BCD preset nibbles saturate to 9, so OUT only ever holds 0..9.
  assign load_bad     = (load_nib > 4'd9);
  assign load_clamped = load_bad ? 4'd9 : load_nib;
endmodule

module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   OUT,
  output logic                  zero,
  output logic                  borrow,
  output logic                  load_err
);
  localparam bit SAT = (WRAP == 0);

  logic [DIGITS:0]            brw;
  logic [DIGITS-1:0][3:0]     dec_val;
  logic [DIGITS-1:0][3:0]     ld_val;
  logic [DIGITS-1:0]          ld_bad;
  logic                       underflow;

  // Digit 0 always sees a borrow-in; en gates whether the result is used.
  assign brw[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .d            (OUT[4*g +: 4]),
      .borrow_in    (brw[g]),
      .load_nib     (load_val[4*g +: 4]),
      .dec          (dec_val[g]),
      .borrow_out   (brw[g+1]),
      .load_clamped (ld_val[g]),
      .load_bad     (ld_bad[g])
    );
  end

  // A borrow leaving the top digit only happens from all-zero.
  assign underflow = brw[DIGITS];
  assign zero      = (OUT == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT      <= '0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      OUT      <= ld_val;
      borrow   <= 1'b0;
      load_err <= |ld_bad;
    end else begin
      load_err <= 1'b0;
      if (en && !(underflow && SAT)) begin
        OUT    <= dec_val;
        borrow <= underflow;
      end else begin
        borrow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench: a WRAP=1 and a WRAP=0 two-digit counter run in lockstep from one vector table,
// plus hand sequences for a long countdown and three-digit ripple.

module tb_bcd_down_counter;
  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [7:0]  lv;
  logic [11:0] lv3;
  logic [7:0]  out1, out0;
  logic [11:0] out3;
  logic        z1, z0, z3, b1, b0, b3, e1, e0, e3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .WRAP(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv),
    .OUT(out1), .zero(z1), .borrow(b1), .load_err(e1));

  bcd_down_counter #(.DIGITS(2), .WRAP(0)) u_w0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv),
    .OUT(out0), .zero(z0), .borrow(b0), .load_err(e0));

  bcd_down_counter #(.DIGITS(3), .WRAP(1)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(lv3),
    .OUT(out3), .zero(z3), .borrow(b3), .load_err(e3));

  typedef struct {
    logic       rst, load, en;
    logic [7:0] lv;
    logic [7:0] o1;
    logic       b1;
    logic [7:0] o0;
    logic       b0;
    logic       err;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic l, logic e, logic [7:0] v,
                              logic [7:0] o1, logic bb1, logic [7:0] o0, logic bb0, logic er);
    vec_t t;
    t.rst = r; t.load = l; t.en = e; t.lv = v;
    t.o1 = o1; t.b1 = bb1; t.o0 = o0; t.b0 = bb0; t.err = er;
    return t;
  endfunction

  function automatic logic [7:0] to_bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step(input logic r, input logic l, input logic e, input logic [7:0] v);
    rst = r; load = l; en = e; lv = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1, n0;
    logic exp_b1;

    //            rst load en  lv      o1    b1  o0    b0  err
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[2]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[4]  = mk(0, 1, 0, 8'h21, 8'h21, 0, 8'h21, 0, 0);
    vecs[5]  = mk(0, 0, 1, 8'h00, 8'h20, 0, 8'h20, 0, 0);
    vecs[6]  = mk(0, 0, 1, 8'h00, 8'h19, 0, 8'h19, 0, 0);
    vecs[7]  = mk(0, 0, 1, 8'h00, 8'h18, 0, 8'h18, 0, 0);
    vecs[8]  = mk(0, 1, 0, 8'h01, 8'h01, 0, 8'h01, 0, 0);
    vecs[9]  = mk(0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[10] = mk(0, 0, 1, 8'h00, 8'h99, 1, 8'h00, 0, 0);
    vecs[11] = mk(0, 0, 1, 8'h00, 8'h98, 0, 8'h00, 0, 0);
    vecs[12] = mk(0, 0, 1, 8'h00, 8'h97, 0, 8'h00, 0, 0);
    vecs[13] = mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[14] = mk(0, 0, 1, 8'h00, 8'h99, 1, 8'h00, 0, 0);
    vecs[15] = mk(0, 0, 1, 8'h00, 8'h98, 0, 8'h00, 0, 0);
    vecs[16] = mk(0, 0, 1, 8'h00, 8'h97, 0, 8'h00, 0, 0);
    vecs[17] = mk(0, 0, 1, 8'h00, 8'h96, 0, 8'h00, 0, 0);
    vecs[18] = mk(0, 1, 1, 8'h3C, 8'h39, 0, 8'h39, 0, 1);
    vecs[19] = mk(0, 0, 1, 8'h00, 8'h38, 0, 8'h38, 0, 0);
    vecs[20] = mk(0, 0, 0, 8'h00, 8'h38, 0, 8'h38, 0, 0);
    vecs[21] = mk(0, 1, 0, 8'h57, 8'h57, 0, 8'h57, 0, 0);
    vecs[22] = mk(0, 0, 1, 8'h00, 8'h56, 0, 8'h56, 0, 0);
    vecs[23] = mk(0, 0, 1, 8'h00, 8'h55, 0, 8'h55, 0, 0);
    vecs[24] = mk(1, 1, 1, 8'h57, 8'h00, 0, 8'h00, 0, 0);
    vecs[25] = mk(0, 1, 0, 8'hFA, 8'h99, 0, 8'h99, 0, 1);
    vecs[26] = mk(0, 1, 0, 8'h9F, 8'h99, 0, 8'h99, 0, 1);
    vecs[27] = mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vecs[28] = mk(0, 1, 0, 8'hAA, 8'h99, 0, 8'h99, 0, 1);
    vecs[29] = mk(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);

    lv3 = '0;
    step(1, 0, 0, 8'h00);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].lv);
      chk("out_w1",    i, 32'(out1), 32'(vecs[i].o1));
      chk("borrow_w1", i, 32'(b1),   32'(vecs[i].b1));
      chk("zero_w1",   i, 32'(z1),   32'(vecs[i].o1 == 8'h00));
      chk("err_w1",    i, 32'(e1),   32'(vecs[i].err));
      chk("out_w0",    i, 32'(out0), 32'(vecs[i].o0));
      chk("borrow_w0", i, 32'(b0),   32'(vecs[i].b0));
      chk("zero_w0",   i, 32'(z0),   32'(vecs[i].o0 == 8'h00));
      chk("err_w0",    i, 32'(e0),   32'(vecs[i].err));
    end

    // Long countdown from 10 through underflow, checked against a decimal model.
    step(0, 1, 0, 8'h10);
    n1 = 10; n0 = 10;
    for (int c = 0; c < 14; c++) begin
      exp_b1 = (n1 == 0);
      n1 = (n1 == 0) ? 99 : n1 - 1;
      n0 = (n0 == 0) ? 0 : n0 - 1;
      step(0, 0, 1, 8'h00);
      chk("cd_out_w1",    c, 32'(out1), 32'(to_bcd(n1)));
      chk("cd_borrow_w1", c, 32'(b1),   32'(exp_b1));
      chk("cd_out_w0",    c, 32'(out0), 32'(to_bcd(n0)));
      chk("cd_borrow_w0", c, 32'(b0),   32'(1'b0));
    end

    // Three-digit ripple through two zero digits, full wrap, and mid-digit clamp.
    lv3 = 12'h100;
    step(0, 1, 0, 8'h00);
    chk("d3_load", 0, 32'(out3), 32'h100);
    step(0, 0, 1, 8'h00);
    chk("d3_ripple", 0, 32'(out3), 32'h099);
    chk("d3_ripple_b", 0, 32'(b3), 32'h0);
    lv3 = 12'h000;
    step(0, 1, 0, 8'h00);
    chk("d3_zero", 0, 32'(z3), 32'h1);
    step(0, 0, 1, 8'h00);
    chk("d3_wrap", 0, 32'(out3), 32'h999);
    chk("d3_wrap_b", 0, 32'(b3), 32'h1);
    lv3 = 12'h0A0;
    step(0, 1, 0, 8'h00);
    chk("d3_clamp", 0, 32'(out3), 32'h090);
    chk("d3_clamp_err", 0, 32'(e3), 32'h1);
    step(0, 0, 0, 8'h00);
    chk("d3_err_pulse", 0, 32'(e3), 32'h0);
    chk("d3_hold", 0, 32'(out3), 32'h090);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
